// File: rtl/fdu_pkg.sv
// ---------------------------------------------------------------------------
// fdu_pkg -- shared definitions for the fetch/decode unit.
//   Opcode constants, instruction field positions and the FSM state enum.
//   Optional feature macro: FDU_BNEZ_EN (enables BNEZ as a control opcode).
// ---------------------------------------------------------------------------
package fdu_pkg;

   // Instruction field positions (16-bit instruction word)
   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   localparam logic [3:0] OP_JMP  = 4'hE;
   localparam logic [3:0] OP_BEQZ = 4'hD;
   localparam logic [3:0] OP_BNEZ = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_HALT  = 2'd3
   } state_e;

endpackage

// File: rtl/fetch_decode_unit_decoder.sv
// ---------------------------------------------------------------------------
// fdu_decoder -- combinational control-flow decode.
//   op_i              opcode field
//   imm8_i            8-bit immediate field
//   zero_i            ALU zero flag
//   is_jump_o         JMP opcode
//   is_branch_taken_o conditional branch whose condition holds
//   is_halt_o         HALT opcode
//   tgt_o             imm8 when a jump/branch is taken, else 0
// Optional feature macro: FDU_BNEZ_EN (BNEZ taken when zero_i=0).
// ---------------------------------------------------------------------------
module fdu_decoder
   import fdu_pkg::*;
(
   input  logic [3:0] op_i,
   input  logic [7:0] imm8_i,
   input  logic       zero_i,
   output logic       is_jump_o,
   output logic       is_branch_taken_o,
   output logic       is_halt_o,
   output logic [7:0] tgt_o
);

   logic beqz_taken;
   logic bnez_taken;

   assign is_jump_o  = (op_i == OP_JMP);
   assign is_halt_o  = (op_i == OP_HALT);
   assign beqz_taken = (op_i == OP_BEQZ) && zero_i;

`ifdef FDU_BNEZ_EN
   assign bnez_taken = (op_i == OP_BNEZ) && !zero_i;
`else
   // Opcode 4'hC is an ordinary non-control instruction in this build.
   assign bnez_taken = 1'b0;
`endif

   assign is_branch_taken_o = beqz_taken || bnez_taken;
   assign tgt_o = (is_jump_o || is_branch_taken_o) ? imm8_i : 8'h00;

endmodule

// File: rtl/fetch_decode_unit.sv
// ---------------------------------------------------------------------------
// fetch_decode_unit -- instruction-side partner of the PC/branch controller.
//   Presents the PC to a synchronous instruction memory, retires the returned
//   instruction into ir, decodes control flow back to the PC controller,
//   squashes the single wrong-path word after a taken jump/branch, and pins
//   the PC on HALT until reset.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   pc           current PC from the PC controller
//   imem_addr    instruction memory address (= pc)
//   imem_rdata   instruction memory data, valid the cycle after the address
//   zero         ALU zero flag for conditional branches
//   branch/jump  take relative branch / absolute jump (combinational)
//   imm          branch offset or jump target, 0 when neither is taken
//   ir/ir_valid  last retired instruction; ir_valid = updated on prior edge
//   halted       core is in HALT
//   retired_cnt  number of retired instructions (wraps)
// Optional feature macro: FDU_BNEZ_EN (decoded in fdu_decoder).
// ---------------------------------------------------------------------------
module fetch_decode_unit
   import fdu_pkg::*;
#(
   parameter int IW = 16,
   parameter int AW = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] pc,
   output logic [AW-1:0] imem_addr,
   input  logic [IW-1:0] imem_rdata,
   input  logic          zero,
   output logic          branch,
   output logic          jump,
   output logic [AW-1:0] imm,
   output logic [IW-1:0] ir,
   output logic          ir_valid,
   output logic          halted,
   output logic [CW-1:0] retired_cnt
);

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q;
   logic [AW-1:0] halt_pc_q, halt_pc_d;
   logic [IW-1:0] ir_q, ir_d;
   logic          ir_valid_q, ir_valid_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          dec_jump, dec_br, dec_halt;
   logic [7:0]    dec_tgt;

   assign imem_addr = pc;

   fdu_decoder u_dec (
      .op_i              (imem_rdata[OP_MSB:OP_LSB]),
      .imm8_i            (imem_rdata[IMM_MSB:IMM_LSB]),
      .zero_i            (zero),
      .is_jump_o         (dec_jump),
      .is_branch_taken_o (dec_br),
      .is_halt_o         (dec_halt),
      .tgt_o             (dec_tgt)
   );

   always_comb begin
      state_d    = state_q;
      branch     = 1'b0;
      jump       = 1'b0;
      imm        = '0;
      ir_d       = ir_q;
      ir_valid_d = 1'b0;
      cnt_d      = cnt_q;
      halt_pc_d  = halt_pc_q;
      case (state_q)
         S_BOOT: state_d = S_RUN;
         S_RUN: begin
            ir_d       = imem_rdata;
            ir_valid_d = 1'b1;
            cnt_d      = cnt_q + CW'(1);
            // HALT is a self-jump to its own address; pc_q is that address.
            if (dec_halt) begin
               jump      = 1'b1;
               imm       = pc_q;
               halt_pc_d = pc_q;
               state_d   = S_HALT;
            end else if (dec_jump) begin
               jump    = 1'b1;
               imm     = AW'(dec_tgt);
               state_d = S_FLUSH;
            end else if (dec_br) begin
               branch  = 1'b1;
               imm     = AW'(dec_tgt);
               state_d = S_FLUSH;
            end
         end
         // Wrong-path word already fetched: drop it, decode nothing.
         S_FLUSH: state_d = S_RUN;
         S_HALT: begin
            jump = 1'b1;
            imm  = halt_pc_q;
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_BOOT;
         pc_q       <= '0;
         halt_pc_q  <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc;
         halt_pc_q  <= halt_pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign ir          = ir_q;
   assign ir_valid    = ir_valid_q;
   assign halted      = (state_q == S_HALT);
   assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
module tb_fetch_decode_unit;

   localparam int AW  = 8;
   localparam int IW  = 16;
   localparam int TCW = 4;   // narrow counter so wrap is reachable quickly
`ifdef FDU_BNEZ_EN
   localparam bit BNEZ_ON = 1'b1;
`else
   localparam bit BNEZ_ON = 1'b0;
`endif
   localparam logic [15:0] NOP = 16'h1000;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          zero = 1'b0;
   logic [AW-1:0] pc, imem_addr, imm, rd_addr;
   logic [IW-1:0] imem_rdata, ir;
   logic          branch, jump, ir_valid, halted;
   logic [TCW-1:0] retired_cnt;
   logic [15:0]   rom [256];

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   bit        m_boot, m_flush, m_halt, m_valid;
   logic [7:0]  m_halt_pc;
   logic [15:0] m_ir;
   int          m_cnt;

   fetch_decode_unit #(.IW(IW), .AW(AW), .CW(TCW)) dut (
      .clk(clk), .reset(reset), .pc(pc), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .zero(zero), .branch(branch), .jump(jump),
      .imm(imm), .ir(ir), .ir_valid(ir_valid), .halted(halted),
      .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   // synchronous instruction memory
   always @(posedge clk) begin
      imem_rdata <= rom[imem_addr];
      rd_addr    <= imem_addr;
   end

   // simple PC controller: branch is relative to the branch's own address
   always @(posedge clk or negedge reset) begin
      if (!reset)      pc <= '0;
      else if (jump)   pc <= imm;
      else if (branch) pc <= rd_addr + imm;
      else             pc <= pc + 8'd1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 256; i++) rom[i] = NOP;
   endtask

   // Check all outputs against the model for the current cycle, then advance
   // the model across the coming clock edge.
   task automatic model_step(input bit advance);
      logic [3:0] op;
      logic       eb, ej, taken;
      logic [7:0] ei;
      op = imem_rdata[15:12];
      eb = 0; ej = 0; ei = 0; taken = 0;
      if (!m_boot && !m_flush) begin
         if (m_halt) begin
            ej = 1; ei = m_halt_pc;
         end else if (op == 4'hF) begin
            ej = 1; ei = rd_addr;
         end else if (op == 4'hE) begin
            ej = 1; ei = imem_rdata[7:0];
         end else if ((op == 4'hD && zero) || (BNEZ_ON && op == 4'hC && !zero)) begin
            eb = 1; ei = imem_rdata[7:0];
         end
      end
      chk("m_branch", branch, eb);
      chk("m_jump", jump, ej);
      chk("m_imm", imm, ei);
      chk("m_halted", halted, m_halt);
      chk("m_ir", ir, m_ir);
      chk("m_ir_valid", ir_valid, m_valid);
      chk("m_cnt", retired_cnt, m_cnt);
      if (!advance) return;
      if (m_boot) begin
         m_boot = 0; m_valid = 0;
      end else if (m_flush || m_halt) begin
         m_flush = 0; m_valid = 0;
      end else begin
         m_ir = imem_rdata; m_valid = 1; m_cnt = (m_cnt + 1) % (1 << TCW);
         if (op == 4'hF) begin
            m_halt = 1; m_halt_pc = rd_addr;
         end else if (ej || eb) begin
            m_flush = 1;
         end
      end
   endtask

   task automatic tick(input logic z);
      zero = z;
      #1;
      model_step(1'b1);
      @(negedge clk);
   endtask

   // Ends at a negedge with reset just released (S_BOOT cycle).
   task automatic do_reset();
      reset = 1'b0;
      m_boot = 1; m_flush = 0; m_halt = 0; m_valid = 0;
      m_ir = '0; m_cnt = 0; m_halt_pc = '0;
      @(negedge clk);
      zero = 1'b0;
      #1 model_step(1'b0);   // reset-state check
      @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      logic [15:0] instr;
      logic        z;
      logic        eb, ej;
      logic [7:0]  ei;
   } vec_t;

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{16'h1234, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{16'hE00A, 1'b0, 1'b0, 1'b1, 8'h0A};
      tbl[2]  = '{16'hD004, 1'b1, 1'b1, 1'b0, 8'h04};
      tbl[3]  = '{16'hD004, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[4]  = '{16'hF000, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[5]  = '{16'hC002, 1'b0, BNEZ_ON, 1'b0, BNEZ_ON ? 8'h02 : 8'h00};
      tbl[6]  = '{16'hC002, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[7]  = '{16'h0000, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[8]  = '{16'hEFFF, 1'b1, 1'b0, 1'b1, 8'hFF};
      tbl[9]  = '{16'hD0FF, 1'b1, 1'b1, 1'b0, 8'hFF};
      tbl[10] = '{16'hB0AA, 1'b1, 1'b0, 1'b0, 8'h00};

      // ---- table: single instruction at address 0
      for (int i = 0; i < 11; i++) begin
         fill_nop();
         rom[0] = tbl[i].instr;
         do_reset();
         tick(1'b0);                       // S_BOOT
         zero = tbl[i].z;
         #1;
         chk($sformatf("tbl%0d_branch", i), branch, tbl[i].eb);
         chk($sformatf("tbl%0d_jump", i), jump, tbl[i].ej);
         chk($sformatf("tbl%0d_imm", i), imm, tbl[i].ei);
         @(negedge clk);
         chk($sformatf("tbl%0d_ir", i), ir, tbl[i].instr);
      end

      // ---- non-control program, count and wrap
      fill_nop();
      do_reset();
      chk("boot_cnt", retired_cnt, 0);
      repeat (6) tick(1'b0);
      chk("cnt5", retired_cnt, 5);
      repeat (12) tick(1'b0);
      chk("cnt_wrap", retired_cnt, 1);

      // ---- JMP at 2 -> 0x0A
      fill_nop();
      rom[2] = 16'hE00A; rom[3] = 16'h3333; rom[8'h0A] = 16'h7777;
      do_reset();
      repeat (3) tick(1'b0);
      zero = 1'b0; #1;
      chk("jmp_jump", jump, 1);
      chk("jmp_imm", imm, 8'h0A);
      tick(1'b0);                          // retire JMP
      tick(1'b0);                          // squash
      chk("jmp_squash_valid", ir_valid, 0);
      chk("jmp_squash_cnt", retired_cnt, 3);
      tick(1'b0);
      chk("jmp_target_ir", ir, 16'h7777);

      // ---- BEQZ at 3, taken then not taken
      fill_nop();
      rom[3] = 16'hD004; rom[4] = 16'h4444; rom[7] = 16'h7070;
      do_reset();
      repeat (4) tick(1'b0);
      zero = 1'b1; #1;
      chk("beqz1_branch", branch, 1);
      chk("beqz1_imm", imm, 8'h04);
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      chk("beqz1_ir", ir, 16'h7070);
      chk("beqz1_cnt", retired_cnt, 5);
      do_reset();
      repeat (4) tick(1'b0);
      zero = 1'b0; #1;
      chk("beqz0_branch", branch, 0);
      tick(1'b0);
      tick(1'b0);
      chk("beqz0_ir", ir, 16'h4444);
      chk("beqz0_valid", ir_valid, 1);
      chk("beqz0_cnt", retired_cnt, 5);

      // ---- HALT at 5, then async reset out of HALT
      fill_nop();
      rom[5] = 16'hF000;
      do_reset();
      repeat (12) tick(1'b0);
      chk("halt_halted", halted, 1);
      chk("halt_jump", jump, 1);
      chk("halt_imm", imm, 8'h05);
      chk("halt_cnt", retired_cnt, 6);
      #2 reset = 1'b0;
      #1;
      chk("halt_rst_halted", halted, 0);
      chk("halt_rst_jump", jump, 0);
      chk("halt_rst_cnt", retired_cnt, 0);

      // ---- JMP followed by wrong-path JMP
      fill_nop();
      rom[1] = 16'hE020; rom[2] = 16'hE040;
      rom[8'h20] = 16'h2222; rom[8'h40] = 16'h4444;
      do_reset();
      repeat (3) tick(1'b0);
      zero = 1'b0; #1;
      chk("jj_flush_jump", jump, 0);
      chk("jj_flush_imm", imm, 0);
      tick(1'b0);
      tick(1'b0);
      chk("jj_target_ir", ir, 16'h2222);

      // ---- async reset in the middle of a flush
      fill_nop();
      rom[1] = 16'hE010;
      do_reset();
      repeat (3) tick(1'b0);
      #2 reset = 1'b0;
      #1;
      chk("flush_rst_valid", ir_valid, 0);
      chk("flush_rst_cnt", retired_cnt, 0);
      chk("flush_rst_ir", ir, 0);

      // ---- randomized programs against the model
      for (int r = 0; r < 8; r++) begin
         for (int a = 0; a < 256; a++) begin
            case ($urandom_range(0, 9))
               0: rom[a] = {4'hE, 4'($urandom), 8'($urandom)};
               1: rom[a] = {4'hD, 4'($urandom), 8'($urandom)};
               2: rom[a] = {4'hC, 4'($urandom), 8'($urandom)};
               3: rom[a] = ($urandom_range(0, 7) == 0) ? {4'hF, 12'($urandom)} : NOP;
               default: rom[a] = {4'($urandom_range(0, 11)), 12'($urandom)};
            endcase
         end
         do_reset();
         repeat (250) tick(1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
